// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Chain of DEPTH pipeline registers with valid/ready flow control, a
//   synchronous flush and an optional one-entry input skid buffer. It sits
//   between CPU pipeline stages and on bus paths that need registering that
//   tolerates stalls, can be flushed, and still moves one word per cycle.
//
// Parameters
//   WIDTH      payload width in bits
//   DEPTH      number of register stages (>= 1)
//   RESET_VAL  value loaded into every data register on reset
//   SKID       1: in_ready comes straight from a flop and a skid entry
//              absorbs the word accepted while the chain is stalled;
//              0: in_ready is combinational back from out_ready
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   flush      synchronous clear of every valid bit (skid included)
//   in_valid   upstream word is valid
//   in_ready   block accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  last stage holds a valid word
//   out_ready  downstream accepts out_data this cycle
//   out_data   last stage payload
//   occupancy  number of valid words held (stages + skid)

module pipe_stage_chain #(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              SKID      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(DEPTH+2)-1:0]  occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 2);

  logic [DEPTH-1:0] stage_v;
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] feed_v;
  logic [WIDTH-1:0] feed_d [DEPTH];
  logic             src_v;
  logic [WIDTH-1:0] src_d;
  logic             skid_v;

  // A stage may take a new word when the downstream side drains this cycle or
  // when there is an empty stage anywhere between it and the output, because
  // every stage in that stretch shifts forward and opens a slot. Collecting
  // the "hole seen so far" from the output backwards gives the same result as
  // the per-stage ripple without a vector that depends on itself.
  always_comb begin : p_advance
    logic hole;
    hole = 1'b0;
    adv  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hole   = hole || !stage_v[k];
      adv[k] = out_ready || hole;
    end
  end

  // What each stage would load when it advances: stage 0 is fed from the
  // input side (skid or live input), every other stage from its predecessor.
  always_comb begin : p_feed
    feed_v = '0;
    for (int k = 0; k < DEPTH; k++) begin
      feed_d[k] = '0;
    end
    feed_v[0] = src_v;
    feed_d[0] = src_d;
    for (int k = 1; k < DEPTH; k++) begin
      feed_v[k] = stage_v[k-1];
      feed_d[k] = stage_d[k-1];
    end
  end

  // Stage registers. Valid bits follow the shift; flush wipes them but leaves
  // the data registers alone. Data only loads when a real word arrives, so a
  // stalled or drained stage keeps showing its last payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stage_d[k] <= RESET_VAL;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush) begin
          stage_v[k] <= 1'b0;
        end else if (adv[k]) begin
          stage_v[k] <= feed_v[k];
          if (feed_v[k]) begin
            stage_d[k] <= feed_d[k];
          end
        end
      end
    end
  end

  if (SKID != 0) begin : g_skid
    logic [WIDTH-1:0] skid_d;

    // in_ready depends only on the skid flop, so upstream timing never sees
    // out_ready. A parked word always goes into stage 0 ahead of new input,
    // which keeps the stream in order.
    assign in_ready = !skid_v;
    assign src_v    = skid_v || in_valid;
    assign src_d    = skid_v ? skid_d : in_data;

    // The skid fills when a word is accepted while stage 0 is blocked and
    // empties on the cycle stage 0 takes it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        skid_v <= 1'b0;
        skid_d <= RESET_VAL;
      end else if (flush) begin
        skid_v <= 1'b0;
      end else if (skid_v) begin
        if (adv[0]) begin
          skid_v <= 1'b0;
        end
      end else if (in_valid && !adv[0]) begin
        skid_v <= 1'b1;
        skid_d <= in_data;
      end
    end
  end else begin : g_noskid
    // Without a skid the input is ready exactly when stage 0 can load.
    assign in_ready = adv[0];
    assign src_v    = in_valid;
    assign src_d    = in_data;
    assign skid_v   = 1'b0;
  end

  // Occupancy is simply the count of valid words anywhere in the block.
  always_comb begin : p_occupancy
    occupancy = OCC_W'(skid_v);
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(stage_v[k]);
    end
  end

  assign out_valid = stage_v[DEPTH-1];
  assign out_data  = stage_d[DEPTH-1];

endmodule
